// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard and decode interlock for the Y86-64 register file.
// Tracks in-flight writes per register (ids 0..14; id 4'hF is never tracked),
// stalls decode on a busy source or a saturating destination, and flags
// counter underflow/overflow in a sticky error bit.
module regfile_scoreboard #(
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [3:0]  dec_srcA,
    input  logic [3:0]  dec_srcB,
    input  logic [3:0]  dec_dstE,
    input  logic [3:0]  dec_dstM,
    output logic        dec_stall,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dstE,
    input  logic [3:0]  wb_dstM,
    input  logic        kill_valid,
    input  logic [3:0]  kill_dstE,
    input  logic [3:0]  kill_dstM,
    output logic [14:0] busy_vec,
    output logic [5:0]  inflight,
    output logic        err
);

    localparam int unsigned NREG  = 15;
    localparam int unsigned SW    = CNT_W + 2;
    localparam int unsigned MAXC  = (1 << CNT_W) - 1;
    localparam int unsigned IFL_W = 6;

    // Number of the two ids (0..2) that name register r; r < 15 so 4'hF never hits.
    function automatic logic [1:0] hits(input logic [3:0] a, input logic [3:0] b,
                                        input int unsigned r);
        hits = 2'(a == 4'(r)) + 2'(b == 4'(r));
    endfunction

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [1:0]       dinc  [NREG];
    logic [1:0]       wbdec [NREG];
    logic [1:0]       kdec  [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [IFL_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;
    logic             issue;

    // Per-register claim/release counts straight from the stage inputs.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            dinc[r]  = hits(dec_dstE, dec_dstM, r);
            wbdec[r] = wb_valid   ? hits(wb_dstE, wb_dstM, r)     : 2'd0;
            kdec[r]  = kill_valid ? hits(kill_dstE, kill_dstM, r) : 2'd0;
        end
    end

    // Decode interlock: busy source or destination that would pass max count.
    always_comb begin : stall_blk
        logic             src_busy;
        logic             sat;
        logic [SW-1:0]    cnt_x;
        logic [SW-1:0]    rem;
        src_busy = 1'b0;
        sat      = 1'b0;
        cnt_x    = '0;
        rem      = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_x = SW'(cnt_q[r]);
            rem   = WB_BYPASS ? (cnt_x - SW'(wbdec[r])) : cnt_x;
            if ((dec_srcA == 4'(r) || dec_srcB == 4'(r)) && rem != '0) begin
                src_busy = 1'b1;
            end
            if (dinc[r] != 2'd0 && (cnt_x + SW'(dinc[r])) > SW'(MAXC)) begin
                sat = 1'b1;
            end
        end
        dec_stall = dec_valid & (src_busy | sat);
    end

    assign issue = dec_valid & ~dec_stall;

    // Counter update with clamping; busy/inflight are derived from the new counts
    // so the registered views line up with the counters.
    always_comb begin : next_blk
        logic [SW-1:0] sum;
        sum        = '0;
        err_d      = err_q;
        busy_d     = '0;
        inflight_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            // Two's-complement in SW bits: range -4..2*MAXC fits, sign bit marks underflow.
            sum = SW'(cnt_q[r]) + (issue ? SW'(dinc[r]) : SW'(0))
                  - SW'(wbdec[r]) - SW'(kdec[r]);
            if (sum[SW-1]) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else if (sum > SW'(MAXC)) begin
                cnt_d[r] = CNT_W'(MAXC);
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum);
            end
            busy_d[r]  = (cnt_d[r] != '0);
            inflight_d = inflight_d + IFL_W'(cnt_d[r]);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q     <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign busy_vec = busy_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule
